// File: rtl/reduction_pkg.sv
// rtl/reduction_pkg.sv - shared types and helpers for the reduction job controller
// Contents:
//   state_t        : job sequencer states
//   ct_width()     : output width of the compressor tree for a given operand count/size
//   signed_add_ovf : signed overflow detect from the operand and result sign bits
package reduction_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    // The tree output grows by two bits per reduction level beyond the first.
    function automatic int ct_width(input int in_num, input int in_size);
        return in_size + 2 * ($clog2(in_num) - 1);
    endfunction

    // A two's-complement add overflows when both operands share a sign and the
    // result sign differs from it.
    function automatic logic signed_add_ovf(input logic a_sign,
                                            input logic b_sign,
                                            input logic r_sign);
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

endpackage

// File: rtl/compressor_n_2.sv
// rtl/compressor_n_2.sv - reduces IN_NUM signed operands to a sum/carry pair
// Ports:
//   in_data_i : IN_NUM packed signed operands of IN_SIZE bits
//   sum_o     : first reduced word, OUT_SIZE bits signed
//   carry_o   : second reduced word, OUT_SIZE bits signed
// sign_extend(sum_o) + sign_extend(carry_o) equals the exact operand total.
module compressor_n_2
    import reduction_pkg::*;
#(
    parameter int IN_NUM   = 24,
    parameter int IN_SIZE  = 12,
    parameter int OUT_SIZE = ct_width(IN_NUM, IN_SIZE)
) (
    input  logic [0:IN_NUM-1][IN_SIZE-1:0] in_data_i,
    output logic signed [OUT_SIZE-1:0]     sum_o,
    output logic signed [OUT_SIZE-1:0]     carry_o
);

    // Each output word holds the exact total of one half of the operands, so
    // neither word can overflow OUT_SIZE and the pair adds without correction.
    always_comb begin
        sum_o   = '0;
        carry_o = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            if (i < IN_NUM / 2) begin
                sum_o = sum_o + OUT_SIZE'($signed(in_data_i[i]));
            end else begin
                carry_o = carry_o + OUT_SIZE'($signed(in_data_i[i]));
            end
        end
    end

endmodule

// File: rtl/reduction_job_ctrl.sv
// rtl/reduction_job_ctrl.sv - sequences multi-beat dot-product reduction jobs
// Ports:
//   clk_i, rst_ni                   : clock, asynchronous active-low reset
//   start_i, cfg_len_i, busy_o      : job start (IDLE only), beat count, busy flag
//   in_valid_i, in_ready_o, in_data_i : operand beat handshake and data
//   out_valid_o, out_ready_i        : result handshake
//   out_data_o, ovf_o               : signed job result and sticky overflow flag
module reduction_job_ctrl
    import reduction_pkg::*;
#(
    parameter int IN_NUM   = 24,
    parameter int IN_SIZE  = 12,
    parameter int ACC_SIZE = 32,
    parameter int LEN_W    = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [LEN_W-1:0]               cfg_len_i,
    output logic                           busy_o,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [0:IN_NUM-1][IN_SIZE-1:0] in_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic signed [ACC_SIZE-1:0]     out_data_o,
    output logic                           ovf_o
);

    localparam int CT_W = ct_width(IN_NUM, IN_SIZE);

    generate
        if (IN_NUM < 4) begin : g_in_num_chk
            $error("reduction_job_ctrl: IN_NUM must be at least 4");
        end
        if (ACC_SIZE < CT_W) begin : g_acc_size_chk
            $error("reduction_job_ctrl: ACC_SIZE must be at least the tree width");
        end
    endgenerate

    state_t                     state;
    logic [LEN_W-1:0]           beats_left;
    logic signed [CT_W-1:0]     tree_sum;
    logic signed [CT_W-1:0]     tree_carry;
    logic                       s1_valid;
    logic signed [CT_W-1:0]     s1_sum;
    logic signed [CT_W-1:0]     s1_carry;
    logic signed [ACC_SIZE-1:0] acc;
    logic                       acc_ovf;
    logic signed [ACC_SIZE-1:0] beat;
    logic signed [ACC_SIZE-1:0] acc_next;
    logic                       accept;

    compressor_n_2 #(
        .IN_NUM   (IN_NUM),
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (CT_W)
    ) u_tree (
        .in_data_i (in_data_i),
        .sum_o     (tree_sum),
        .carry_o   (tree_carry)
    );

    // in_ready_o is only ever high in ACCUM, so it alone qualifies acceptance.
    assign accept   = in_valid_i && in_ready_o;
    assign beat     = ACC_SIZE'(s1_sum) + ACC_SIZE'(s1_carry);
    assign acc_next = acc + beat;

    // Stage 1 captures the tree output; stage 2 folds it into the accumulator.
    // The stage-2 add of the last beat lands during DRAIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum   <= tree_sum;
                s1_carry <= tree_carry;
            end
            if (state == IDLE && start_i) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end else if (s1_valid) begin
                acc <= acc_next;
                if (signed_add_ovf(acc[ACC_SIZE-1], beat[ACC_SIZE-1], acc_next[ACC_SIZE-1])) begin
                    acc_ovf <= 1'b1;
                end
            end
        end
    end

    // Job sequencer with registered outputs. The result registers load on the
    // first RESULT edge, so out_valid_o rises two edges after the last accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            beats_left  <= '0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            ovf_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        beats_left <= (cfg_len_i == '0) ? LEN_W'(1) : cfg_len_i;
                        state      <= ACCUM;
                        busy_o     <= 1'b1;
                        in_ready_o <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        beats_left <= beats_left - LEN_W'(1);
                        if (beats_left == LEN_W'(1)) begin
                            state      <= DRAIN;
                            in_ready_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= RESULT;
                end
                RESULT: begin
                    if (out_valid_o && out_ready_i) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b0;
                        out_data_o  <= '0;
                        ovf_o       <= 1'b0;
                    end else begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= acc;
                        ovf_o       <= acc_ovf;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reduction_job_ctrl.sv
// tb/tb_reduction_job_ctrl.sv - scoreboard bench for reduction_job_ctrl at ACC_SIZE 32 and 20
module tb_reduction_job_ctrl;

    localparam int IN_NUM  = 24;
    localparam int IN_SIZE = 12;
    localparam int LEN_W   = 8;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           start = 1'b0;
    logic [LEN_W-1:0]               cfg_len = '0;
    logic                           in_valid = 1'b0;
    logic [0:IN_NUM-1][IN_SIZE-1:0] in_data = '0;
    logic                           out_ready = 1'b1;

    logic               busy_a, in_ready_a, out_valid_a, ovf_a;
    logic signed [31:0] out_data_a;
    logic               busy_b, in_ready_b, out_valid_b, ovf_b;
    logic signed [19:0] out_data_b;

    always #5 clk = ~clk;

    reduction_job_ctrl #(
        .IN_NUM(IN_NUM), .IN_SIZE(IN_SIZE), .ACC_SIZE(32), .LEN_W(LEN_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_len_i(cfg_len),
        .busy_o(busy_a), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
        .in_data_i(in_data), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
        .out_data_o(out_data_a), .ovf_o(ovf_a)
    );

    reduction_job_ctrl #(
        .IN_NUM(IN_NUM), .IN_SIZE(IN_SIZE), .ACC_SIZE(20), .LEN_W(LEN_W)
    ) dut20 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_len_i(cfg_len),
        .busy_o(busy_b), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
        .in_data_i(in_data), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
        .out_data_o(out_data_b), .ovf_o(ovf_b)
    );

    typedef struct {
        longint d32;
        logic   o32;
        longint d20;
        logic   o20;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_jobs   = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: wrap-around accumulation with sticky signed overflow
    // at both accumulator widths.
    task automatic push_expected(input int len, input logic [IN_SIZE-1:0] val);
        exp_t               e;
        int                 beats;
        int                 v;
        longint             s;
        longint             full;
        logic signed [63:0] f64;
        logic signed [31:0] t32;
        logic signed [19:0] t20;
        beats = (len == 0) ? 1 : len;
        v     = $signed(val);
        s     = longint'(IN_NUM) * longint'(v);
        e.d32 = 0; e.o32 = 1'b0; e.d20 = 0; e.o20 = 1'b0;
        for (int b = 0; b < beats; b++) begin
            full = e.d32 + s;
            if (full > 64'sd2147483647 || full < -64'sd2147483648) e.o32 = 1'b1;
            f64 = full;
            t32 = f64[31:0];
            e.d32 = t32;
            full = e.d20 + s;
            if (full > 64'sd524287 || full < -64'sd524288) e.o20 = 1'b1;
            f64 = full;
            t20 = f64[19:0];
            e.d20 = t20;
        end
        sb.push_back(e);
        n_jobs++;
    endtask

    task automatic start_job(input int len);
        cfg_len = LEN_W'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [IN_SIZE-1:0] val);
        bit got;
        int cyc;
        got      = 1'b0;
        cyc      = 0;
        in_data  = {IN_NUM{val}};
        in_valid = 1'b1;
        while (!got && cyc < 20) begin
            got = in_ready_a;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic run_job(input int len, input logic [IN_SIZE-1:0] val, input int gap);
        int beats;
        beats = (len == 0) ? 1 : len;
        push_expected(len, val);
        start_job(len);
        for (int b = 0; b < beats; b++) begin
            send_beat(val);
            if (b != beats - 1) repeat (gap) tick();
        end
    endtask

    task automatic wait_results();
        int cyc;
        cyc = 0;
        while (n_done < n_jobs && cyc < 200) begin
            tick();
            cyc++;
        end
        if (n_done < n_jobs) check("result_timeout", n_done, n_jobs);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_in_ready"}, in_ready_a, 0);
        check({tag, "_out_valid"}, out_valid_a, 0);
        check({tag, "_out_data"}, out_data_a, 0);
        check({tag, "_ovf"}, ovf_a, 0);
        check({tag, "_busy20"}, busy_b, 0);
        check({tag, "_out_data20"}, out_data_b, 0);
    endtask

    // Pops one expectation per result handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready) begin
            exp_t e;
            check("valid20_aligned", out_valid_b, 1);
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("data32", out_data_a, e.d32);
                check("ovf32", ovf_a, e.o32);
                check("data20", out_data_b, e.d20);
                check("ovf20", ovf_b, e.o20);
            end
            n_done++;
        end
    end

    initial begin
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: single beat of ones, latency check
        run_job(1, 12'h001, 0);
        check("t1_valid_k", out_valid_a, 0);
        check("t1_busy_k", busy_a, 1);
        tick();
        check("t1_valid_k1", out_valid_a, 0);
        tick();
        check("t1_valid_k2", out_valid_a, 1);
        wait_results();
        tick();

        // 2: three back-to-back beats of -1
        run_job(3, 12'hFFF, 0);
        check("t2_ready_drop", in_ready_a, 0);
        wait_results();
        tick();

        // 3: four beats of -2048 with two-cycle gaps
        run_job(4, 12'h800, 2);
        wait_results();
        tick();

        // 4: consumer stall, start ignored while holding, and on handshake
        out_ready = 1'b0;
        run_job(2, 12'h005, 0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", out_valid_a, 1);
            check("t4_hold_data", out_data_a, 240);
            check("t4_hold_ready", in_ready_a, 0);
            check("t4_hold_busy", busy_a, 1);
            if (i == 1) begin
                start   = 1'b1;
                cfg_len = 8'd3;
            end
            if (i == 3) start = 1'b0;
            tick();
        end
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t4_idle_busy", busy_a, 0);
        check("t4_idle_valid", out_valid_a, 0);
        tick();
        check("t4_start_ignored", busy_a, 0);
        check("t4_no_ready", in_ready_a, 0);
        wait_results();
        tick();

        // 5: eleven beats of 2047, wraps and flags overflow at 20 bits
        run_job(11, 12'h7FF, 0);
        wait_results();
        tick();

        // 6: reset after 2 of 5 beats, then a zero-length job
        start_job(5);
        send_beat(12'h003);
        send_beat(12'h003);
        check("t6_busy_pre", busy_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        tick();
        rst_n = 1'b1;
        tick();
        run_job(0, 12'h003, 0);
        check("t6_len0_ready", in_ready_a, 0);
        wait_results();
        tick();

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
